proc_instr_sequencer: RTL and testbench

PROC_INSTR_SEQUENCER -- requirements
Module: proc_instr_sequencer

---
 rtl/proc_instr_sequencer_pkg.sv | 36 +++
 rtl/proc_prog_mem.sv | 28 ++
 rtl/proc_instr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_proc_instr_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_instr_sequencer_pkg.sv
// Shared definitions for the processor instruction sequencer: opcode values,
// sequencer state encoding and the immediate-operand decode helper.
package proc_instr_sequencer_pkg;

  localparam int WORD_W = 9;
  localparam int OP_W   = 3;

  // Opcode field values (word bits [8:6]).
  localparam logic [OP_W-1:0] OP_DISP = 3'd0;
  localparam logic [OP_W-1:0] OP_MOV  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADDI = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
  localparam logic [OP_W-1:0] OP_AND  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_MOVI = 3'd7;

  // Processor tick that marks the first cycle of an instruction.
  localparam logic [3:0] TICK_1 = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_FIN
  } seq_state_t;

  // Instructions that carry a second word holding an immediate operand.
  function automatic logic has_immediate(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/proc_prog_mem.sv
// Program memory: DEPTH words of 9 bits, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a sequencer reset.
module proc_prog_mem
  import proc_instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/proc_instr_sequencer.sv
// Instruction sequencer: streams a stored program to a 4-tick processor, one
// word per tick slot. T1 carries the instruction, T2 its immediate (ADDI/MOVI)
// or zero, T3/T4 zero. Execution aligns once to tick 1 and then runs
// back-to-back until the program length is consumed or a halt is seen.
module proc_instr_sequencer
  import proc_instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              halt,
  input  logic [3:0]        tick_FSM,
  output logic [WORD_W-1:0] din,
  output logic [AW:0]       pc,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              imm_err,
  output logic [7:0]        instr_count
);

  localparam logic [AW:0] ADDR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ADDR_TWO = {{(AW-1){1'b0}}, 2'b10};
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);

  seq_state_t        state;
  logic [AW:0]       len;
  logic              step2;
  logic              halt_seen;
  logic [AW:0]       pc_inc1;
  logic [AW:0]       pc_inc2;
  logic [AW:0]       pc_next;
  logic [AW:0]       rd_full;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] fetch_word;
  logic              imm_here;
  logic              imm_fits;
  logic              mem_we;

  // Writes are only honoured while the sequencer is idle.
  assign mem_we = wr_en & ~busy;

  proc_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_full[AW-1:0]),
    .rd_data (rd_data)
  );

  // Address arithmetic is AW+1 bits wide; pc never exceeds prog_len, so it
  // cannot wrap.
  assign pc_inc1  = pc + ADDR_ONE;
  assign pc_inc2  = pc + ADDR_TWO;
  assign pc_next  = step2 ? pc_inc2 : pc_inc1;
  assign imm_here = has_immediate(din[8:6]);
  assign imm_fits = pc_inc1 < len;

  // Single read port: the address depends on which word the next edge loads.
  always_comb begin
    rd_full = pc;
    if (state == ST_T1) begin
      rd_full = pc_inc1;
    end else if (state == ST_T4) begin
      rd_full = pc_next;
    end
  end

  // Addresses past the physical memory read as zero.
  assign fetch_word = (rd_full < DEPTH_W) ? rd_data : '0;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      step2       <= 1'b0;
      halt_seen   <= 1'b0;
      din         <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      imm_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len         <= prog_len;
            pc          <= '0;
            instr_count <= '0;
            imm_err     <= 1'b0;
            aborted     <= 1'b0;
            halt_seen   <= 1'b0;
            step2       <= 1'b0;
            busy        <= 1'b1;
            din         <= '0;
            state       <= (prog_len == '0) ? ST_FIN : ST_SYNC;
          end
        end
        ST_SYNC: begin
          // Halt before the first instruction ends immediately.
          if (halt) begin
            halt_seen <= 1'b1;
            state     <= ST_FIN;
          end else if (tick_FSM == TICK_1) begin
            din   <= fetch_word;
            state <= ST_T1;
          end
        end
        ST_T1: begin
          halt_seen <= halt_seen | halt;
          if (imm_here && imm_fits) begin
            din   <= fetch_word;
            step2 <= 1'b1;
          end else begin
            // A missing immediate is flagged and the opcode word alone is consumed.
            din   <= '0;
            step2 <= 1'b0;
            if (imm_here) begin
              imm_err <= 1'b1;
            end
          end
          state <= ST_T2;
        end
        ST_T2: begin
          halt_seen <= halt_seen | halt;
          din       <= '0;
          state     <= ST_T3;
        end
        ST_T3: begin
          halt_seen <= halt_seen | halt;
          state     <= ST_T4;
        end
        ST_T4: begin
          pc <= pc_next;
          if (instr_count != 8'hFF) begin
            instr_count <= instr_count + 8'd1;
          end
          // Instructions always complete; the program ends only at this boundary.
          if (halt_seen || halt || (pc_next >= len)) begin
            halt_seen <= halt_seen | halt;
            din       <= '0;
            state     <= ST_FIN;
          end else begin
            din   <= fetch_word;
            state <= ST_T1;
          end
        end
        ST_FIN: begin
          done    <= 1'b1;
          aborted <= halt_seen;
          busy    <= 1'b0;
          din     <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Directed testbench for proc_instr_sequencer with a per-cycle scoreboard.
module tb_proc_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic [4:0] prog_len;
  logic       start;
  logic       halt;
  logic [3:0] tick_FSM;
  logic [8:0] din;
  logic [4:0] pc;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       imm_err;
  logic [7:0] instr_count;

  typedef struct {
    logic [8:0] din;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       imm_err;
    logic [7:0] cnt;
    logic [4:0] pc;
  } rec_t;

  rec_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         tph = 0;
  logic [8:0] shadow [0:15];

  proc_instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .prog_len    (prog_len),
    .start       (start),
    .halt        (halt),
    .tick_FSM    (tick_FSM),
    .din         (din),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .imm_err     (imm_err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tph = (tph + 1) % 4;
    tick_FSM = 4'b0001 << tph;
  endtask

  task automatic align(input int p);
    while (tph != p) step();
  endtask

  task automatic wr(input int a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; shadow[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic void add(input logic [8:0] d, input logic b, input logic dn,
                              input logic ab, input logic ie, input int c, input int p);
    rec_t r;
    r.din = d; r.busy = b; r.done = dn; r.aborted = ab; r.imm_err = ie;
    r.cnt = 8'(c); r.pc = 5'(p);
    q.push_back(r);
  endfunction

  // Reference behaviour: one record per cycle after the start edge.
  // hi = -1 no halt, 0 halt in first SYNC cycle, k halt during T2 of instruction k.
  task automatic build(input int len, input int p, input int hi, output int halt_at);
    int q1, n, pcm, cnt, st;
    logic ie;
    logic [8:0] w, w2;
    halt_at = -1;
    q1 = (p + 1) % 4;
    n = ((4 - q1) % 4) + 1;
    if (len == 0) begin
      add(0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      return;
    end
    if (hi == 0) begin
      halt_at = 0;
      add(0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0);
      return;
    end
    for (int i = 0; i < n; i++) add(0, 1, 0, 0, 0, 0, 0);
    pcm = 0; cnt = 0; ie = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      w = shadow[pcm]; w2 = 9'd0; st = 1;
      if (w[8:6] == 3'd2 || w[8:6] == 3'd7) begin
        if (pcm + 1 < len) begin w2 = shadow[pcm + 1]; st = 2; end
        else ie = 1'b1;
      end
      add(w, 1, 0, 0, 0, 0, 0);
      add(w2, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0);
      pcm += st; cnt++;
      if (hi == k) halt_at = n + 4 * (k - 1) + 1;
      if (pcm >= len || hi == k) break;
    end
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, (hi > 0), ie, cnt, pcm);
  endtask

  // Start a program and check every cycle until the done pulse.
  // junk: hammer start/wr_en/prog_len while busy; wr0: write address 0 in the start cycle.
  task automatic run(input string name, input int len, input int hi, input bit junk,
                     input bit wr0, input logic [8:0] d0);
    rec_t r;
    int   idx, halt_at;
    prog_len = 5'(len);
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = d0; shadow[0] = d0;
    end
    build(len, tph, hi, halt_at);
    step();
    start = 1'b0; wr_en = 1'b0;
    idx = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      chk($sformatf("%s din[%0d]", name, idx), 16'(din), 16'(r.din));
      chk($sformatf("%s busy[%0d]", name, idx), 16'(busy), 16'(r.busy));
      chk($sformatf("%s done[%0d]", name, idx), 16'(done), 16'(r.done));
      if (r.done) begin
        chk($sformatf("%s aborted", name), 16'(aborted), 16'(r.aborted));
        chk($sformatf("%s imm_err", name), 16'(imm_err), 16'(r.imm_err));
        chk($sformatf("%s instr_count", name), 16'(instr_count), 16'(r.cnt));
        chk($sformatf("%s pc", name), 16'(pc), 16'(r.pc));
      end
      halt = (idx == halt_at);
      if (junk && r.busy) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 9'h1FF; prog_len = 5'd0;
      end
      step();
      halt = 1'b0; start = 1'b0; wr_en = 1'b0; prog_len = 5'(len);
      idx++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    start = 1'b0; halt = 1'b0; tick_FSM = 4'b0001;
    for (int i = 0; i < 16; i++) shadow[i] = 9'd0;
    #3;
    chk("reset din", 16'(din), 16'd0);
    chk("reset pc", 16'(pc), 16'd0);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset aborted", 16'(aborted), 16'd0);
    chk("reset imm_err", 16'(imm_err), 16'd0);
    chk("reset instr_count", 16'(instr_count), 16'd0);
    step();
    rst = 1'b1;
    step();

    // MOVI with immediate followed by a plain instruction; busy-time writes/starts ignored.
    wr(0, 9'd448); wr(1, 9'd10); wr(2, 9'd16);
    run("basic", 3, -1, 1'b1, 1'b0, 9'd0);

    // Start while tick 3 is active: waits for tick 1; memory must be untouched by junk writes.
    align(2);
    run("sync", 3, -1, 1'b0, 1'b0, 9'd0);

    // Immediate instruction as last valid word.
    run("immerr", 1, -1, 1'b0, 1'b0, 9'd0);

    // Empty program; imm_err must have been cleared by the new start.
    run("empty", 0, -1, 1'b0, 1'b0, 9'd0);

    // Halt while waiting for tick 1.
    run("haltsync", 3, 0, 1'b0, 1'b0, 9'd0);

    // Five single-word instructions, halt in T2 of instruction 2.
    wr(0, 9'o123); wr(1, 9'o345); wr(2, 9'o456); wr(3, 9'o567); wr(4, 9'o612);
    run("halt", 5, 2, 1'b0, 1'b0, 9'd0);

    // Asynchronous reset during T3 of instruction 2.
    n = ((4 - ((tph + 1) % 4)) % 4) + 1;
    prog_len = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (n + 6) step();
    chk("prerst busy", 16'(busy), 16'd1);
    chk("prerst pc", 16'(pc), 16'd1);
    chk("prerst instr_count", 16'(instr_count), 16'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst din", 16'(din), 16'd0);
    chk("midrst pc", 16'(pc), 16'd0);
    chk("midrst busy", 16'(busy), 16'd0);
    chk("midrst done", 16'(done), 16'd0);
    chk("midrst instr_count", 16'(instr_count), 16'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("inrst done[%0d]", i), 16'(done), 16'd0);
      chk($sformatf("inrst din[%0d]", i), 16'(din), 16'd0);
    end
    rst = 1'b1;
    step();
    chk("postrst done", 16'(done), 16'd0);
    run("replay", 5, -1, 1'b0, 1'b0, 9'd0);

    // Write and start in the same cycle: execution sees the new word.
    run("wrstart", 2, -1, 1'b0, 1'b1, 9'o734);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
